// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: boot-time loader for the single-cycle core.
// Keeps the core in reset and receives a program image over a byte stream.
// Image layout: word count N (16-bit, little-endian), 4*N payload bytes
// (little-endian per word), then one byte holding the XOR of the payload.
// Each word is written to instruction memory at word addresses 0..N-1. The
// core is released only when the checksum matches.
// While loading, the loader drives the instruction-memory address port.
// In RUN, the core PC drives it.
module boot_load_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    input  logic [31:0]       cpu_pc,
    output logic              cpu_reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   loaded_words
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_SIZE = 2'b10;
    localparam logic [1:0] ERR_TIME = 2'b11;

    // The idle counter saturates at TIMEOUT-1. The limit is reached when a
    // further idle cycle is seen at that count.
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Largest image that fits into instruction memory.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          err_nxt;

    logic                xfer;          // byte handshake completes this cycle
    logic                restart;       // reload accepted: clear the load context
    logic                active;        // states where the idle timer runs
    logic                timed_out;
    logic                last_word;
    logic [15:0]         hdr_n;

    logic [7:0]          n_lo;          // low byte of the word count, held until HDR1
    logic [15:0]         n_words;       // word count of the current image
    logic [1:0]          byte_idx;      // byte position inside the current word
    logic [23:0]         word_buf;      // first three bytes of the current word
    logic [ADDR_W:0]     word_cnt;      // words already handed to memory
    logic [7:0]          xor_acc;       // running XOR of the payload bytes
    logic [IDLE_W-1:0]   idle_cnt;
    logic [ADDR_W-1:0]   wr_addr;       // address of the word being written

    logic                unused_pc_bits;

    assign xfer      = rx_valid & rx_ready;
    assign restart   = reload & ((state == S_RUN) || (state == S_ERROR));
    assign active    = (state == S_HDR1) || (state == S_DATA) || (state == S_CSUM);
    assign timed_out = (TIMEOUT != 0) && active && !xfer && (idle_cnt == IDLE_MAX);

    // The current word is the last one when the running word count plus one
    // equals N. The oversize check limits N, so the count never wraps.
    assign last_word = ((16'(word_cnt) + 16'd1) == n_words);

    assign loaded_words = word_cnt;

    // Address port: the core owns it only while it runs.
    // Otherwise the loader write index drives it.
    assign imem_addr = (state == S_RUN) ? cpu_pc[ADDR_W+1:2] : wr_addr;

    // PC byte offset and high bits are outside the instruction-memory range.
    assign unused_pc_bits = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

    // State register and latched error code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_HDR0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
        end
    end

    // Next-state logic. A byte accepted in the same cycle the idle limit
    // is hit wins over the timeout.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        hdr_n     = {rx_data, n_lo};
        case (state)
            S_HDR0: begin
                if (xfer) state_nxt = S_HDR1;
            end
            S_HDR1: begin
                if (xfer) begin
                    if ({1'b0, hdr_n} > MAX_WORDS) begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_SIZE;
                    end else if (hdr_n == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else if (timed_out) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_TIME;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (byte_idx == 2'd3 && last_word) state_nxt = S_CSUM;
                end else if (timed_out) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_TIME;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data == xor_acc) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_CSUM;
                    end
                end else if (timed_out) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_TIME;
                end
            end
            S_RUN: begin
                if (reload) state_nxt = S_HDR0;
            end
            S_ERROR: begin
                if (reload) begin
                    state_nxt = S_HDR0;
                    err_nxt   = ERR_NONE;
                end
            end
            default: begin
                state_nxt = S_HDR0;
                err_nxt   = ERR_NONE;
            end
        endcase
    end

    // Output decode from the state register.
    // cpu_reset therefore drops on the cycle after the checksum byte.
    always_comb begin
        rx_ready  = 1'b0;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_HDR0: rx_ready = 1'b1;
            S_HDR1, S_DATA, S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    // Idle timer: counts non-transfer cycles while a load is in progress.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            idle_cnt <= '0;
        end else if (xfer || !active) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Load datapath.
    // - Header capture and word assembly.
    // - Checksum accumulation.
    // - A registered one-cycle write strobe after each fourth payload byte.
    // The byte stream is never stalled by a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_lo       <= '0;
            n_words    <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            word_cnt   <= '0;
            xor_acc    <= '0;
            wr_addr    <= '0;
            imem_we    <= 1'b0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                n_lo     <= '0;
                n_words  <= '0;
                byte_idx <= '0;
                word_buf <= '0;
                word_cnt <= '0;
                xor_acc  <= '0;
                wr_addr  <= '0;
            end else if (xfer) begin
                case (state)
                    S_HDR0: n_lo <= rx_data;
                    S_HDR1: n_words <= hdr_n;
                    S_DATA: begin
                        xor_acc  <= xor_acc ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, word_buf};
                                wr_addr    <= word_cnt[ADDR_W-1:0];
                                word_cnt   <= word_cnt + (ADDR_W+1)'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/boot_load_ctrl.md
Name: boot_load_ctrl

Overview:
- Boot-time sequencer for the single-cycle ARMv4 core.
- Holds the core in reset and receives a program image over a byte stream. Writes the image word-by-word into instruction memory, checks a checksum, then releases the core.
- Arbitrates the instruction-memory address port: the loader owns it while loading; the core's PC owns it in RUN.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (capacity 2**ADDR_W words).
- TIMEOUT, 1000, max idle cycles between bytes once a load has started; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  byte available
- rx_data  in  8  byte value
- rx_ready  out  1  loader accepts byte (transfer = rx_valid & rx_ready)
- reload  in  1  single-cycle pulse; restarts a load from RUN or ERROR
- cpu_pc  in  32  core PC
- cpu_reset  out  1  reset to the core
- imem_addr  out  ADDR_W  instruction-memory word address
- imem_we  out  1  instruction-memory write enable
- imem_wdata  out  32  instruction-memory write data
- busy  out  1  in HDR1, DATA or CSUM
- done  out  1  in RUN
- error  out  1  in ERROR
- err_code  out  2  01 checksum, 10 oversize, 11 timeout, 00 none
- loaded_words  out  ADDR_W+1  words written in the current/last load

Behaviour:
- Reset is synchronous, active-high, on posedge clk. Values after reset:
  - state HDR0, rx_ready=1, cpu_reset=1, imem_we=0, imem_wdata=0
  - error=0, err_code=00, loaded_words=0, busy=0, done=0
  - counters cleared
- Reset mid-load aborts the load. Already-written memory words are not cleared.
- Image format: N_lo, N_hi (16-bit word count, little-endian), then 4*N payload bytes, then one checksum byte.
  - Payload is little-endian per word, written to word addresses 0..N-1.
  - Checksum = XOR of all payload bytes; header bytes are excluded; equals 0x00 when N=0.
- States and transitions:
  - HDR0: accept byte -> latch N_lo -> HDR1. No timeout in this state.
  - HDR1: accept byte -> latch N_hi.
    - N > 2**ADDR_W -> ERROR, err_code=10.
    - N=0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: shift bytes into the word buffer (first byte -> bits 7:0). On the 4th byte of each word:
    - the next cycle has imem_we=1 for exactly one cycle, with imem_wdata=word and imem_addr=word index;
    - loaded_words increments in that same cycle.
    - After the last byte of word N-1 -> CSUM.
  - CSUM: accept byte. Equal to running XOR -> RUN; otherwise -> ERROR, err_code=01.
  - RUN: rx_ready=0, cpu_reset=0, done=1, imem_addr=cpu_pc[ADDR_W+1:2]. reload -> HDR0.
  - ERROR: rx_ready=0, cpu_reset=1, error=1, err_code held. reload -> HDR0 and clears err_code, loaded_words, XOR and word buffer.
- rx_ready=1 in HDR0, HDR1, DATA and CSUM. It stays 1 during a pending write, so byte acceptance and imem_we may coincide.
- cpu_reset is 1 in every state except RUN. It is decoded from the state register, so it deasserts the cycle after the checksum byte is accepted.
- Address arbitration: in any state other than RUN, imem_addr = loader write index; in RUN, the core owns it. The last memory write always completes before RUN is entered.
- Timeout: an idle counter runs in HDR1, DATA and CSUM and clears on every accepted byte. If TIMEOUT consecutive cycles pass without a transfer -> ERROR, err_code=11. A byte accepted in the same cycle the limit is hit takes priority (no error).
- reload is ignored in HDR0, HDR1, DATA and CSUM. reset has priority over reload.
- Word index and loaded_words are ADDR_W+1 bits wide and never wrap, because the oversize check bounds N.

Test Plan:
- Good load, ADDR_W=6. Bytes 02 00 05 00 A0 E3 01 10 80 E2 35, rx_valid held 1 ->
  - imem writes at addr 0 (0xE3A00005) and addr 1 (0xE2801001), one cycle each;
  - cpu_reset falls one cycle after byte 0x35 is accepted; done=1, loaded_words=2;
  - imem_addr then tracks cpu_pc=0x8 -> 2.
- Bad checksum. Same image with last byte 0x34 -> error=1, err_code=01, cpu_reset stays 1, rx_ready=0; two words were written.
- Oversize. Bytes 41 00 -> ERROR, err_code=10 after the 2nd byte; no imem_we.
- Timeout, TIMEOUT=10. Bytes 01 00 05, then rx_valid=0 for 10 cycles -> ERROR, err_code=11; a byte arriving on cycle 9 instead keeps the load alive.
- Zero length and reload.
  - Bytes 00 00 00 -> RUN, no writes.
  - Then a reload pulse -> HDR0, cpu_reset=1, loaded_words=0; a new load succeeds.
- Reset mid-load. Assert reset after 3 payload bytes -> next cycle state HDR0, imem_we=0, cpu_reset=1; a fresh full image then loads correctly.
